// File: rtl/cdc_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_arb_pkg
// Description : Shared types and the round-robin pick function for the
//               asynchronous event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_arb_pkg;

  localparam int unsigned MAX_CH   = 16;
  localparam int unsigned MAX_CH_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  // Return {found, index}: first set bit of pend scanning upward from ptr+1,
  // wrapping modulo n_ch. Bits at or above n_ch are ignored.
  function automatic logic [MAX_CH_W:0] rr_pick(
    input logic [MAX_CH-1:0]   pend,
    input logic [MAX_CH_W-1:0] ptr,
    input int unsigned         n_ch
  );
    logic [MAX_CH_W:0] res;
    int unsigned       idx;
    res = '0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      idx = (32'(ptr) + k) % n_ch;
      if ((k <= n_ch) && !res[MAX_CH_W] && pend[idx]) begin
        res = {1'b1, idx[MAX_CH_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage : cdc_arb_pkg
`default_nettype wire

// File: rtl/cdc_event_arbiter_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Multi-flop synchronizer for one asynchronous line followed by
//               a rising-edge detector in the destination clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_dest,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  // Shift the asynchronous line through the synchronizer chain.
  always_ff @(posedge clk_dest or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], async_in};
    end
  end

  // Remember the previous synchronized level; reset to 0 so a line already
  // high at reset release produces exactly one event.
  always_ff @(posedge clk_dest or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= sync_out;
    end
  end

  assign sync_out = r_chain[SYNC_STAGES-1];
  assign rise     = sync_out & ~r_prev;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/cdc_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_event_arbiter
// Description : Synchronizes N_CH asynchronous event lines, latches rising
//               edges as pending events and offers them one at a time to a
//               valid/ready consumer with round-robin fairness. Events that
//               arrive while a channel already has one pending set a sticky
//               overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_event_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk_dest,
  input  logic                     rst,
  input  logic [N_CH-1:0]          async_req,
  output logic                     grant_valid,
  output logic [$clog2(N_CH)-1:0]  grant_ch,
  input  logic                     grant_ready,
  output logic [N_CH-1:0]          pending,
  output logic [N_CH-1:0]          overflow,
  input  logic [N_CH-1:0]          overflow_clr
);

  localparam int unsigned CH_W = $clog2(N_CH);

  logic [N_CH-1:0]   w_sync;
  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   r_pending;
  logic [N_CH-1:0]   r_overflow;
  logic [CH_W-1:0]   r_grant_ch;
  logic [CH_W-1:0]   r_rr_ptr;
  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_load;
  logic [MAX_CH_W:0] w_pick;
  logic              w_found;
  logic [CH_W-1:0]   w_winner;
  logic [N_CH-1:0]   w_load_vec;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk_dest (clk_dest),
        .rst      (rst),
        .async_in (async_req[gi]),
        .sync_out (w_sync[gi]),
        .rise     (w_rise[gi])
      );
    end
  endgenerate

  // Round-robin winner among currently pending channels.
  assign w_pick     = rr_pick(16'(r_pending), 4'(r_rr_ptr), N_CH);
  assign w_found    = w_pick[MAX_CH_W];
  assign w_winner   = CH_W'(w_pick[MAX_CH_W-1:0]);
  assign w_load_vec = w_load ? (N_CH'(1) << w_winner) : '0;

  // Pending: a loaded channel is cleared, but a coincident new edge re-sets
  // it. Overflow: an edge hitting an already-pending, not-being-loaded
  // channel; a set beats a simultaneous clear.
  always_ff @(posedge clk_dest or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_load_vec) | w_rise;
      r_overflow <= (r_overflow & ~overflow_clr) | (w_rise & r_pending & ~w_load_vec);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_dest or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and load decision; an accepted offer is replaced in the
  // same cycle when anything is pending, so there is no idle bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (grant_ready) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: valid follows the state flop so reset drops it at once.
  always_comb begin
    grant_valid = (r_state == ST_OFFER);
  end

  // Offer register and round-robin pointer update on every load.
  always_ff @(posedge clk_dest or posedge rst) begin
    if (rst) begin
      r_grant_ch <= '0;
      r_rr_ptr   <= CH_W'(N_CH - 1);
    end else if (w_load) begin
      r_grant_ch <= w_winner;
      r_rr_ptr   <= w_winner;
    end
  end

  assign grant_ch = r_grant_ch;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule : cdc_event_arbiter
`default_nettype wire
